// File: rtl/usr_cmd_sequencer.sv
// Purpose: command-driven controller for a universal shift register (ctrl 00 hold, 01 shl, 10 shr, 11 load).
// Latency: done pulses N'+USR_LAT+1 cycles after the accept cycle (N' = RUN cycles actually spent).
// Backpressure: one command in flight; cmd_ready is high only in IDLE, so a held cmd_valid waits out DONE.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_op/cmd_count/cmd_data sampled only on accept
//   abort               stops issuing ops of the current command (honoured in RUN only)
//   usr_ctrl, usr_d     sole drive of the USR control and data inputs
//   usr_q               USR output, captured on the last DRAIN cycle
//   result_data         captured usr_q, held until the next capture
//   done                one-cycle pulse; aborted and ops_issued are valid alongside it
module usr_cmd_sequencer #(
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 4,
    parameter int USR_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic [1:0]       usr_ctrl,
    output logic [WIDTH-1:0] usr_d,
    input  logic [WIDTH-1:0] usr_q,
    output logic [WIDTH-1:0] result_data,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] ops_issued
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // Drain counter counts USR_LAT-1 down to 0, so it must hold USR_LAT.
    localparam int DRN_W = (USR_LAT < 2) ? 1 : $clog2(USR_LAT + 1);
    localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(USR_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] rem_q;     // RUN cycles still to go, including the current one
    logic [CNT_W-1:0] ops_q;
    logic             aborted_q;
    logic [DRN_W-1:0] drn_q;
    logic [WIDTH-1:0] result_q;

    logic             accept;
    logic [CNT_W-1:0] n_req;
    logic             run_abort;
    logic             run_last;
    logic             drn_last;

    assign accept    = cmd_valid && (state == S_IDLE);
    // A load is always exactly one ctrl cycle; other ops repeat cmd_count times.
    assign n_req     = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;
    assign run_abort = (state == S_RUN) && abort;
    assign run_last  = (rem_q == CNT_W'(1));
    assign drn_last  = (drn_q == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        usr_ctrl  = OP_HOLD;
        usr_d     = '0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = (n_req == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                // abort gates the op off in the very cycle it is seen, so the
                // USR never executes an op after abort is raised.
                usr_ctrl = abort ? OP_HOLD : op_q;
                usr_d    = (op_q == OP_LOAD) ? data_q : '0;
                if (abort || run_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drn_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched command, counters, captured result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_HOLD;
            data_q    <= '0;
            rem_q     <= '0;
            ops_q     <= '0;
            aborted_q <= 1'b0;
            drn_q     <= DRN_INIT;
            result_q  <= '0;
        end else begin
            if (accept) begin
                op_q      <= cmd_op;
                data_q    <= cmd_data;
                rem_q     <= n_req;
                ops_q     <= '0;
                aborted_q <= 1'b0;
            end

            if (state == S_RUN) begin
                if (run_abort) begin
                    aborted_q <= 1'b1;
                end else begin
                    // Bounded by N, which itself fits in CNT_W, so no wrap.
                    ops_q <= ops_q + CNT_W'(1);
                    rem_q <= rem_q - CNT_W'(1);
                end
            end

            // Keep the drain counter primed outside DRAIN so every entry
            // path (from IDLE with N=0, or from RUN) starts a full drain.
            if (state == S_DRAIN) begin
                if (drn_last) begin
                    result_q <= usr_q;
                end else begin
                    drn_q <= drn_q - DRN_W'(1);
                end
            end else begin
                drn_q <= DRN_INIT;
            end
        end
    end

    assign result_data = result_q;
    assign aborted     = aborted_q;
    assign ops_issued  = ops_q;

endmodule
